// File: rtl/data_bus_arbiter_if.sv
// Shared processor data-bus bundle: request side (read enables, source values,
// conflict clear) and the registered bus outputs produced by the arbiter.
interface data_bus_arbiter_if #(
  parameter int unsigned SRC_COUNT = 16,
  parameter int unsigned WIDTH     = 12
);
  localparam int unsigned IdxW = $clog2(SRC_COUNT);

  logic [SRC_COUNT-1:0]       read_en;
  logic [SRC_COUNT*WIDTH-1:0] src_data;
  logic                       conflict_clr;
  logic [WIDTH-1:0]           dataout;
  logic                       out_valid;
  logic [IdxW-1:0]            out_src;
  logic                       conflict;
  logic [7:0]                 conflict_count;

  // Request/source side: drives enables and source values, observes the bus.
  modport master (
    output read_en, src_data, conflict_clr,
    input  dataout, out_valid, out_src, conflict, conflict_count
  );

  // Arbiter side.
  modport slave (
    input  read_en, src_data, conflict_clr,
    output dataout, out_valid, out_src, conflict, conflict_count
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Registered data-bus arbiter: picks one of SRC_COUNT sources from read_en,
// using fixed-priority or round-robin arbitration, and loads it onto the bus
// one cycle later. Multiple simultaneous requests are flagged (sticky) and
// counted (saturating at 255).
module data_bus_arbiter #(
  parameter int unsigned SRC_COUNT   = 16,
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned DEFAULT_SRC = 1,
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned HOLD_IDLE   = 0
) (
  input logic               clk,
  input logic               reset,
  data_bus_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(SRC_COUNT);
  localparam logic [IdxW-1:0] DefIdx  = IdxW'(DEFAULT_SRC);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SRC_COUNT - 1);

  // Elaboration-time parameter sanity checks.
  if (SRC_COUNT < 2) begin : gen_bad_src_count
    $error("data_bus_arbiter: SRC_COUNT must be at least 2");
  end
  if (DEFAULT_SRC >= SRC_COUNT) begin : gen_bad_default_src
    $error("data_bus_arbiter: DEFAULT_SRC must be below SRC_COUNT");
  end
  if (ARB_MODE > 1) begin : gen_bad_arb_mode
    $error("data_bus_arbiter: ARB_MODE must be 0 or 1");
  end
  if (HOLD_IDLE > 1) begin : gen_bad_hold_idle
    $error("data_bus_arbiter: HOLD_IDLE must be 0 or 1");
  end

  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic [IdxW-1:0]  out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       conflict_cnt_q, conflict_cnt_d;

  logic             any_req;
  logic             multi_req;
  logic [IdxW-1:0]  grant_idx;

  // Request summary: clearing the lowest set bit leaves something iff >= 2 bits set.
  always_comb begin
    any_req   = |bus.read_en;
    multi_req = |(bus.read_en & (bus.read_en - SRC_COUNT'(1)));
  end

  // Winner selection: lowest index, or first requester at/after rr_ptr with wrap.
  always_comb begin
    int unsigned     scan;
    logic [IdxW-1:0] scan_idx;
    logic            found;
    grant_idx = '0;
    scan      = 0;
    scan_idx  = '0;
    found     = 1'b0;
    if (ARB_MODE == 0) begin
      for (int unsigned k = 0; k < SRC_COUNT; k++) begin
        scan_idx = IdxW'(k);
        if (!found && bus.read_en[scan_idx]) begin
          found     = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end else begin
      for (int unsigned k = 0; k < SRC_COUNT; k++) begin
        scan = 32'(rr_ptr_q) + k;
        if (scan >= SRC_COUNT) begin
          scan = scan - SRC_COUNT;
        end
        scan_idx = IdxW'(scan);
        if (!found && bus.read_en[scan_idx]) begin
          found     = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  // Next-state for the bus registers, round-robin pointer and conflict tracking.
  always_comb begin
    dataout_d      = dataout_q;
    out_src_d      = out_src_q;
    out_valid_d    = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    conflict_d     = conflict_q;
    conflict_cnt_d = conflict_cnt_q;

    if (any_req) begin
      dataout_d   = bus.src_data[grant_idx*WIDTH +: WIDTH];
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      rr_ptr_d    = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);
    end else if (HOLD_IDLE == 0) begin
      dataout_d = bus.src_data[DEFAULT_SRC*WIDTH +: WIDTH];
      out_src_d = DefIdx;
    end

    // A conflict in the same cycle as a clear restarts the count at one.
    if (multi_req) begin
      conflict_d = 1'b1;
      if (bus.conflict_clr) begin
        conflict_cnt_d = 8'd1;
      end else if (conflict_cnt_q != 8'hFF) begin
        conflict_cnt_d = conflict_cnt_q + 8'd1;
      end
    end else if (bus.conflict_clr) begin
      conflict_d     = 1'b0;
      conflict_cnt_d = 8'd0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataout_q      <= '0;
      out_src_q      <= '0;
      out_valid_q    <= 1'b0;
      rr_ptr_q       <= '0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= 8'd0;
    end else begin
      dataout_q      <= dataout_d;
      out_src_q      <= out_src_d;
      out_valid_q    <= out_valid_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.dataout        = dataout_q;
    bus.out_src        = out_src_q;
    bus.out_valid      = out_valid_q;
    bus.conflict       = conflict_q;
    bus.conflict_count = conflict_cnt_q;
  end

`ifndef SYNTHESIS
  // The sticky flag and the count always agree, since the count never wraps to zero.
  a_flag_matches_count : assert property (@(posedge clk) disable iff (!reset)
    conflict_q == (conflict_cnt_q != 8'd0));
  a_src_in_range : assert property (@(posedge clk) disable iff (!reset)
    32'(out_src_q) < SRC_COUNT);
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: three instances (fixed priority, round-robin,
// fixed priority with idle hold) share one stimulus stream; a reference model
// pushes expected outputs per instance, compared after each clock edge.
module tb_data_bus_arbiter;
  localparam int unsigned N    = 16;
  localparam int unsigned W    = 12;
  localparam int          NCfg = 3;
  localparam int          DefaultSrc = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]   read_en;
  logic           conflict_clr;
  logic [W-1:0]   src [N];
  logic [N*W-1:0] src_packed;

  always #5 clk = ~clk;

  // Pack the per-source values onto the shared source bus.
  always_comb begin
    src_packed = '0;
    for (int i = 0; i < N; i++) src_packed[i*W +: W] = src[i];
  end

  data_bus_arbiter_if #(.SRC_COUNT(N), .WIDTH(W)) bus0 ();
  data_bus_arbiter_if #(.SRC_COUNT(N), .WIDTH(W)) bus1 ();
  data_bus_arbiter_if #(.SRC_COUNT(N), .WIDTH(W)) bus2 ();

  assign bus0.read_en = read_en;  assign bus0.src_data = src_packed;
  assign bus0.conflict_clr = conflict_clr;
  assign bus1.read_en = read_en;  assign bus1.src_data = src_packed;
  assign bus1.conflict_clr = conflict_clr;
  assign bus2.read_en = read_en;  assign bus2.src_data = src_packed;
  assign bus2.conflict_clr = conflict_clr;

  data_bus_arbiter #(.SRC_COUNT(N), .WIDTH(W), .DEFAULT_SRC(DefaultSrc), .ARB_MODE(0),
                     .HOLD_IDLE(0)) u_dut_fixed (.clk(clk), .reset(reset), .bus(bus0));
  data_bus_arbiter #(.SRC_COUNT(N), .WIDTH(W), .DEFAULT_SRC(DefaultSrc), .ARB_MODE(1),
                     .HOLD_IDLE(0)) u_dut_rr (.clk(clk), .reset(reset), .bus(bus1));
  data_bus_arbiter #(.SRC_COUNT(N), .WIDTH(W), .DEFAULT_SRC(DefaultSrc), .ARB_MODE(0),
                     .HOLD_IDLE(1)) u_dut_hold (.clk(clk), .reset(reset), .bus(bus2));

  logic [W-1:0] obs_data  [NCfg];
  logic         obs_valid [NCfg];
  logic [3:0]   obs_src   [NCfg];
  logic         obs_conf  [NCfg];
  logic [7:0]   obs_cnt   [NCfg];

  assign obs_data[0] = bus0.dataout;   assign obs_valid[0] = bus0.out_valid;
  assign obs_src[0]  = bus0.out_src;   assign obs_conf[0]  = bus0.conflict;
  assign obs_cnt[0]  = bus0.conflict_count;
  assign obs_data[1] = bus1.dataout;   assign obs_valid[1] = bus1.out_valid;
  assign obs_src[1]  = bus1.out_src;   assign obs_conf[1]  = bus1.conflict;
  assign obs_cnt[1]  = bus1.conflict_count;
  assign obs_data[2] = bus2.dataout;   assign obs_valid[2] = bus2.out_valid;
  assign obs_src[2]  = bus2.out_src;   assign obs_conf[2]  = bus2.conflict;
  assign obs_cnt[2]  = bus2.conflict_count;

  int cfg_arb  [NCfg] = '{0, 1, 0};
  int cfg_hold [NCfg] = '{0, 0, 1};

  // Reference model state per instance.
  logic [W-1:0] m_data  [NCfg];
  logic         m_valid [NCfg];
  logic [3:0]   m_src   [NCfg];
  logic         m_conf  [NCfg];
  logic [7:0]   m_cnt   [NCfg];
  int           m_rr    [NCfg];

  typedef struct {
    int           cfg;
    logic [W-1:0] data;
    logic         valid;
    logic [3:0]   src;
    logic         conf;
    logic [7:0]   cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int mode, input int rr);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (req[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCfg; c++) begin
      m_data[c] = '0; m_valid[c] = 1'b0; m_src[c] = '0;
      m_conf[c] = 1'b0; m_cnt[c] = '0; m_rr[c] = 0;
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_push();
    exp_t e;
    int   g;
    for (int c = 0; c < NCfg; c++) begin
      g = pick(read_en, cfg_arb[c], m_rr[c]);
      if (g >= 0) begin
        m_data[c] = src[g]; m_src[c] = 4'(g); m_valid[c] = 1'b1; m_rr[c] = (g + 1) % N;
      end else begin
        m_valid[c] = 1'b0;
        if (cfg_hold[c] == 0) begin
          m_data[c] = src[DefaultSrc]; m_src[c] = 4'(DefaultSrc);
        end
      end
      if ($countones(read_en) >= 2) begin
        m_conf[c] = 1'b1;
        if (conflict_clr) m_cnt[c] = 8'd1;
        else if (m_cnt[c] != 8'd255) m_cnt[c] = m_cnt[c] + 8'd1;
      end else if (conflict_clr) begin
        m_conf[c] = 1'b0; m_cnt[c] = 8'd0;
      end
      e.cfg = c; e.data = m_data[c]; e.valid = m_valid[c]; e.src = m_src[c];
      e.conf = m_conf[c]; e.cnt = m_cnt[c];
      exp_q.push_back(e);
    end
  endtask

  task automatic score();
    exp_t e;
    check_val("scoreboard depth", 32'(exp_q.size()), 32'(NCfg));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val($sformatf("dut%0d dataout", e.cfg), 32'(obs_data[e.cfg]), 32'(e.data));
      check_val($sformatf("dut%0d out_valid", e.cfg), 32'(obs_valid[e.cfg]), 32'(e.valid));
      check_val($sformatf("dut%0d out_src", e.cfg), 32'(obs_src[e.cfg]), 32'(e.src));
      check_val($sformatf("dut%0d conflict", e.cfg), 32'(obs_conf[e.cfg]), 32'(e.conf));
      check_val($sformatf("dut%0d conflict_count", e.cfg), 32'(obs_cnt[e.cfg]), 32'(e.cnt));
    end
  endtask

  task automatic check_reset(input string tag);
    for (int c = 0; c < NCfg; c++) begin
      check_val($sformatf("%s dut%0d dataout", tag, c), 32'(obs_data[c]), 32'h0);
      check_val($sformatf("%s dut%0d out_valid", tag, c), 32'(obs_valid[c]), 32'h0);
      check_val($sformatf("%s dut%0d out_src", tag, c), 32'(obs_src[c]), 32'h0);
      check_val($sformatf("%s dut%0d conflict", tag, c), 32'(obs_conf[c]), 32'h0);
      check_val($sformatf("%s dut%0d conflict_count", tag, c), 32'(obs_cnt[c]), 32'h0);
    end
  endtask

  task automatic rand_src();
    for (int i = 0; i < N; i++) src[i] = 12'($urandom);
  endtask

  // One cycle: drive at the falling edge, compare 1 time unit after the rising edge.
  task automatic step(input logic [N-1:0] req, input logic clr);
    read_en      = req;
    conflict_clr = clr;
    model_push();
    @(posedge clk);
    #1;
    score();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] req;
    read_en      = '0;
    conflict_clr = 1'b0;
    rand_src();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_reset("por");

    // Load non-zero state so the asynchronous reset has something to clear.
    src[3] = 12'h5A5;
    step(16'h000C, 1'b0);

    // Reset asserted mid-cycle discards the pending grant.
    src[0]  = 12'h3A5;
    read_en = 16'h0001;
    #2 reset = 1'b0;
    #1 check_reset("async");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    step(16'h0001, 1'b0);
    check_val("t1 dataout", 32'(obs_data[0]), 32'h3A5);
    check_val("t1 out_src", 32'(obs_src[0]), 32'h0);
    check_val("t1 out_valid", 32'(obs_valid[0]), 32'h1);

    // Fixed priority, AC against DR.
    src[0]  = 12'h111;
    src[15] = 12'hFFF;
    step(16'h8001, 1'b0);
    check_val("t2 dataout", 32'(obs_data[0]), 32'h111);
    check_val("t2 out_src", 32'(obs_src[0]), 32'h0);
    check_val("t2 conflict", 32'(obs_conf[0]), 32'h1);
    check_val("t2 conflict_count", 32'(obs_cnt[0]), 32'h1);

    // Round-robin rotation; clear alongside the first conflict restarts the count.
    step(16'h8001, 1'b1);
    check_val("t3 rr src c1", 32'(obs_src[1]), 32'd0);
    step(16'h8001, 1'b0);
    check_val("t3 rr src c2", 32'(obs_src[1]), 32'd15);
    step(16'h8001, 1'b0);
    check_val("t3 rr src c3", 32'(obs_src[1]), 32'd0);
    check_val("t3 rr count", 32'(obs_cnt[1]), 32'd3);

    // Idle with default source.
    src[1] = 12'h0C3;
    step(16'h0000, 1'b0);
    check_val("t4 dataout", 32'(obs_data[0]), 32'h0C3);
    check_val("t4 out_src", 32'(obs_src[0]), 32'h1);
    check_val("t4 out_valid", 32'(obs_valid[0]), 32'h0);

    // Idle hold: later source changes do not reach the bus.
    src[2] = 12'h456;
    step(16'h0004, 1'b0);
    src[2] = 12'h789;
    step(16'h0000, 1'b0);
    check_val("t5 hold dataout", 32'(obs_data[2]), 32'h456);
    check_val("t5 hold out_valid", 32'(obs_valid[2]), 32'h0);

    // Saturation, then clear without and with a concurrent conflict.
    for (int i = 0; i < 300; i++) begin
      rand_src();
      req = 16'h8001 | 16'($urandom);
      step(req, 1'b0);
    end
    check_val("t6 saturated fixed", 32'(obs_cnt[0]), 32'd255);
    check_val("t6 saturated rr", 32'(obs_cnt[1]), 32'd255);
    step(16'h0004, 1'b1);
    check_val("t6 clr conflict", 32'(obs_conf[0]), 32'h0);
    check_val("t6 clr count", 32'(obs_cnt[0]), 32'h0);
    step(16'h0006, 1'b1);
    check_val("t6 clr+conf conflict", 32'(obs_conf[0]), 32'h1);
    check_val("t6 clr+conf count", 32'(obs_cnt[0]), 32'h1);

    // Mixed random traffic: idle, one-hot and multi-request cycles.
    for (int i = 0; i < 200; i++) begin
      rand_src();
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = 16'(1) << $urandom_range(0, N - 1);
        default: req = 16'($urandom);
      endcase
      step(req, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

- Parametrised, registered successor to the single-cycle data-bus multiplexer.
- Selects one of `SRC_COUNT` register sources onto the shared `WIDTH`-bit processor data bus from a one-hot-intended `read_en` vector.
- Resolves multiple simultaneous `read_en` bits by fixed-priority or round-robin arbitration, and flags and counts those conflicts.
- Sits between the register sources (AC, register file, DR, etc.) and every bus consumer; all outputs are registered, with 1-cycle latency.

## Interface

Parameters:
- `SRC_COUNT`, default 16: number of bus sources; must be ≥ 2.
- `WIDTH`, default 12: data width of each source and of the bus.
- `DEFAULT_SRC`, default 1: source index driven when no `read_en` bit is set and `HOLD_IDLE` = 0.
- `ARB_MODE`, default 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.
- `HOLD_IDLE`, default 0: idle behaviour. 1 = `dataout` holds its last value when idle. 0 = `dataout` takes source `DEFAULT_SRC` when idle.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `read_en`  input  `SRC_COUNT`  per-source read request; bit i selects source i.
- `src_data`  input  `SRC_COUNT*WIDTH`  packed source values; source i occupies bits [i*WIDTH +: WIDTH].
- `conflict_clr`  input  1  synchronous clear for `conflict` and `conflict_count`.
- `dataout`  output  `WIDTH`  registered bus value.
- `out_valid`  output  1  high when `dataout` was loaded from a requested source in the previous cycle.
- `out_src`  output  `$clog2(SRC_COUNT)`  index of the source loaded into `dataout`.
- `conflict`  output  1  sticky flag: at least two `read_en` bits were set in one cycle.
- `conflict_count`  output  8  saturating count of conflict cycles.

## Operation

- **Request cycle:** any `read_en` bit set.
  - Winner g is chosen by the arbitration rule below.
  - Next edge: `dataout` ← source g, `out_src` ← g, `out_valid` ← 1.
- **Fixed priority (`ARB_MODE` = 0):** g = lowest set index.
- **Round-robin (`ARB_MODE` = 1):**
  - Internal pointer `rr_ptr`, width `$clog2(SRC_COUNT)`.
  - g = first set bit scanning `rr_ptr`, `rr_ptr`+1, … with wrap from `SRC_COUNT`-1 to 0.
  - After any grant, `rr_ptr` ← (g+1) mod `SRC_COUNT`.
  - `rr_ptr` is unchanged on idle cycles.
- **Idle cycle:** no `read_en` bits set. `out_valid` ← 0.
  - `HOLD_IDLE` = 1: `dataout` and `out_src` hold.
  - `HOLD_IDLE` = 0: `dataout` ← source `DEFAULT_SRC`, `out_src` ← `DEFAULT_SRC`.
- **Conflict:** popcount(`read_en`) ≥ 2.
  - Arbitration still grants exactly one source.
  - `conflict` ← 1.
  - `conflict_count` increments, saturating at 255.
- **`conflict_clr` = 1:**
  - Without a conflict in the same cycle: `conflict` ← 0, `conflict_count` ← 0.
  - With a simultaneous conflict: the new conflict wins, giving `conflict` ← 1 and `conflict_count` ← 1.
- **Source sampling:** `src_data` is sampled only at the grant edge. Later changes to the source do not affect `dataout` until the next grant.

## Timing

- Latency: request in cycle n → `dataout`, `out_src`, `out_valid` valid after edge n+1. Back-to-back requests give one transfer per cycle.
- No combinational path from any input to any output.
- Reset (`reset` low, asynchronous, takes effect immediately, independent of `clk`):
  - `dataout` = 0, `out_valid` = 0, `out_src` = 0.
  - `conflict` = 0, `conflict_count` = 0, `rr_ptr` = 0.
- Reset mid-transfer: the pending grant is discarded. First grant after release uses `rr_ptr` = 0.
- Deassertion of `reset` is synchronised externally. The first active edge after release behaves as a normal cycle.
- Counter saturation: at 255 further conflicts leave the count at 255. Only `conflict_clr` or reset clears it.

## Test plan

1. **Reset:** assert `reset` low mid-cycle with `read_en`=0x0001 → all outputs 0 immediately. Release, then one edge → `dataout`=AC value 0x3A5, `out_src`=0, `out_valid`=1.
2. **Fixed priority, AC vs DR:** `ARB_MODE`=0, `read_en`=0x8001, source 0 = 0x111, source 15 = 0xFFF → `dataout`=0x111, `out_src`=0, `conflict`=1, `conflict_count`=1.
3. **Round-robin rotation:** `ARB_MODE`=1, `read_en`=0x8001 held 3 cycles → `out_src` sequence 0, 15, 0; `conflict_count`=3.
4. **Idle, default source:** `HOLD_IDLE`=0, `read_en`=0, source 1 = 0x0C3 → `dataout`=0x0C3, `out_src`=1, `out_valid`=0.
5. **Idle, hold:** `HOLD_IDLE`=1, grant source 2 = 0x456, then `read_en`=0 and source 2 → 0x789 → `dataout` stays 0x456, `out_valid`=0.
6. **Saturation and clear:**
   - 300 consecutive conflict cycles → `conflict_count`=255.
   - `conflict_clr`=1 with `read_en`=0x0004 → `conflict`=0, count=0.
   - `conflict_clr`=1 with `read_en`=0x0006 → `conflict`=1, count=1.
